// File: rtl/regfile_pkg.sv
// Shared register-file writeback definitions.
// Widths, the queued write entry type and the zero register index.
package regfile_pkg;

  localparam int DATA_W = 32;
  localparam int ADDR_W = 5;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } wb_entry_t;

  localparam logic [ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/wbq_bypass.sv
// Youngest-match search over the pending writeback entries.
// Ports: addr_q/data_q/valid/head (queue view), addr in; hit/data out.
module wbq_bypass
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DW     = DATA_W,
  parameter int AW     = ADDR_W,
  parameter int PTR_W  = $clog2(DEPTH)
) (
  input  logic [DEPTH-1:0][AW-1:0] addr_q,
  input  logic [DEPTH-1:0][DW-1:0] data_q,
  input  logic [DEPTH-1:0]         valid,
  input  logic [PTR_W-1:0]         head,
  input  logic [AW-1:0]            addr,
  output logic                     hit,
  output logic [DW-1:0]            data
);

  logic [PTR_W-1:0] idx;

  // Walk oldest to youngest so the last match wins.
  always_comb begin
    hit  = 1'b0;
    data = '0;
    idx  = '0;
    for (int k = 0; k < DEPTH; k++) begin
      idx = head + PTR_W'(k);
      if (valid[idx] && addr_q[idx] == addr &&
          addr != AW'(REG_ZERO)) begin
        hit  = 1'b1;
        data = data_q[idx];
      end
    end
  end

endmodule

// File: rtl/regfile_wb_queue.sv
// In-order writeback FIFO merging load and ALU results onto one RF port.
// Ports: mem_*/alu_* producers, rf_* write port, byp_* read-side bypass.
module regfile_wb_queue
  import regfile_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int DATA_W = regfile_pkg::DATA_W,
  parameter int ADDR_W = regfile_pkg::ADDR_W
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_addr,
  input  logic [DATA_W-1:0] mem_data,
  input  logic              alu_valid,
  output logic              alu_ready,
  input  logic [ADDR_W-1:0] alu_addr,
  input  logic [DATA_W-1:0] alu_data,
  output logic              rf_wen,
  output logic [ADDR_W-1:0] rf_waddr,
  output logic [DATA_W-1:0] rf_wdata,
  input  logic [ADDR_W-1:0] byp_addr1,
  output logic              byp_hit1,
  output logic [DATA_W-1:0] byp_data1,
  input  logic [ADDR_W-1:0] byp_addr2,
  output logic              byp_hit2,
  output logic [DATA_W-1:0] byp_data2
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [DEPTH-1:0][ADDR_W-1:0] addr_q;
  logic [DEPTH-1:0][DATA_W-1:0] data_q;
  logic [PTR_W-1:0]             head;
  logic [PTR_W-1:0]             tail;
  logic [CNT_W-1:0]             count;

  logic [CNT_W-1:0] free;
  logic             mem_push;
  logic             alu_push;
  logic             pop;
  logic [PTR_W-1:0] alu_slot;
  logic [DEPTH-1:0] valid;
  logic [PTR_W-1:0] off;

  // Credit only registered free space; a same-cycle pop is ignored.
  assign free      = CNT_W'(DEPTH) - count;
  assign mem_ready = (free != '0);
  assign alu_ready = (free >= CNT_W'(2)) ||
                     ((free != '0) && !mem_valid);

  // r0 writes complete the handshake but never occupy a slot.
  assign mem_push = mem_valid && mem_ready &&
                    (mem_addr != ADDR_W'(REG_ZERO));
  assign alu_push = alu_valid && alu_ready &&
                    (alu_addr != ADDR_W'(REG_ZERO));
  assign alu_slot = tail + PTR_W'(mem_push);
  assign pop      = (count != '0);

  assign rf_wen   = pop;
  assign rf_waddr = pop ? addr_q[head] : '0;
  assign rf_wdata = pop ? data_q[head] : '0;

  always_comb begin
    valid = '0;
    off   = '0;
    for (int i = 0; i < DEPTH; i++) begin
      off      = PTR_W'(i) - head;
      valid[i] = ({1'b0, off} < count);
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      data_q <= '0;
      head   <= '0;
      tail   <= '0;
      count  <= '0;
    end else begin
      if (mem_push) begin
        addr_q[tail] <= mem_addr;
        data_q[tail] <= mem_data;
      end
      if (alu_push) begin
        addr_q[alu_slot] <= alu_addr;
        data_q[alu_slot] <= alu_data;
      end
      if (pop) head <= head + 1'b1;
      tail  <= tail + PTR_W'(mem_push) + PTR_W'(alu_push);
      count <= count + CNT_W'(mem_push) +
               CNT_W'(alu_push) - CNT_W'(pop);
    end
  end

  wbq_bypass #(
    .DEPTH (DEPTH),
    .DW    (DATA_W),
    .AW    (ADDR_W)
  ) u_byp1 (
    .addr_q (addr_q),
    .data_q (data_q),
    .valid  (valid),
    .head   (head),
    .addr   (byp_addr1),
    .hit    (byp_hit1),
    .data   (byp_data1)
  );

  wbq_bypass #(
    .DEPTH (DEPTH),
    .DW    (DATA_W),
    .AW    (ADDR_W)
  ) u_byp2 (
    .addr_q (addr_q),
    .data_q (data_q),
    .valid  (valid),
    .head   (head),
    .addr   (byp_addr2),
    .hit    (byp_hit2),
    .data   (byp_data2)
  );

endmodule

// File: tb/tb_regfile_wb_queue.sv
// Directed bench for regfile_wb_queue.
// Scenario tasks with inline checks and a commit log.
module tb_regfile_wb_queue;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        mem_valid = 1'b0;
  logic        mem_ready;
  logic [4:0]  mem_addr = '0;
  logic [31:0] mem_data = '0;
  logic        alu_valid = 1'b0;
  logic        alu_ready;
  logic [4:0]  alu_addr = '0;
  logic [31:0] alu_data = '0;
  logic        rf_wen;
  logic [4:0]  rf_waddr;
  logic [31:0] rf_wdata;
  logic [4:0]  byp_addr1 = '0;
  logic        byp_hit1;
  logic [31:0] byp_data1;
  logic [4:0]  byp_addr2 = '0;
  logic        byp_hit2;
  logic [31:0] byp_data2;

  int tests = 0;
  int fails = 0;
  logic [36:0] log_q[$];

  regfile_wb_queue dut (
    .clock     (clock),
    .reset     (reset),
    .mem_valid (mem_valid),
    .mem_ready (mem_ready),
    .mem_addr  (mem_addr),
    .mem_data  (mem_data),
    .alu_valid (alu_valid),
    .alu_ready (alu_ready),
    .alu_addr  (alu_addr),
    .alu_data  (alu_data),
    .rf_wen    (rf_wen),
    .rf_waddr  (rf_waddr),
    .rf_wdata  (rf_wdata),
    .byp_addr1 (byp_addr1),
    .byp_hit1  (byp_hit1),
    .byp_data1 (byp_data1),
    .byp_addr2 (byp_addr2),
    .byp_hit2  (byp_hit2),
    .byp_data2 (byp_data2)
  );

  always #5 clock = ~clock;

  // A write shown at the negedge commits on the next rising edge.
  always @(negedge clock)
    if (rf_wen === 1'b1 && !reset)
      log_q.push_back({rf_waddr, rf_wdata});

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic idle();
    mem_valid = 1'b0;
    alu_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    #3;
    tests++;
    if ({rf_wen, rf_waddr, rf_wdata} !== 38'd0) begin
      fails++;
      $display("FAIL reset_rf got %b/%h/%h want 0/00/0",
               rf_wen, rf_waddr, rf_wdata);
    end
    tests++;
    if ({mem_ready, alu_ready} !== 2'b11) begin
      fails++;
      $display("FAIL reset_ready got %b want 11",
               {mem_ready, alu_ready});
    end
    tests++;
    if ({byp_hit1, byp_data1, byp_hit2, byp_data2} !== 66'd0) begin
      fails++;
      $display("FAIL reset_byp got %b/%h want 0/0",
               byp_hit1, byp_data1);
    end
    tick();
    reset = 1'b0;
    tick();
  endtask

  task automatic test_single_push();
    alu_valid = 1'b1;
    alu_addr  = 5'd7;
    alu_data  = 32'h1234;
    #1;
    tests++;
    if (alu_ready !== 1'b1) begin
      fails++;
      $display("FAIL single_ready got %b want 1", alu_ready);
    end
    tick();
    idle();
    tests++;
    if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd7, 32'h1234}) begin
      fails++;
      $display("FAIL single_rf got %b/%0d/%h want 1/7/1234",
               rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    tests++;
    if (rf_wen !== 1'b0) begin
      fails++;
      $display("FAIL single_after got %b want 0", rf_wen);
    end
  endtask

  task automatic test_dual_push();
    mem_valid = 1'b1;
    mem_addr  = 5'd3;
    mem_data  = 32'hAAAA;
    alu_valid = 1'b1;
    alu_addr  = 5'd4;
    alu_data  = 32'hBBBB;
    #1;
    tests++;
    if ({mem_ready, alu_ready} !== 2'b11) begin
      fails++;
      $display("FAIL dual_ready got %b want 11",
               {mem_ready, alu_ready});
    end
    tick();
    idle();
    tests++;
    if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd3, 32'hAAAA}) begin
      fails++;
      $display("FAIL dual_first got %b/%0d/%h want 1/3/aaaa",
               rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    tests++;
    if ({rf_wen, rf_waddr, rf_wdata} !== {1'b1, 5'd4, 32'hBBBB}) begin
      fails++;
      $display("FAIL dual_second got %b/%0d/%h want 1/4/bbbb",
               rf_wen, rf_waddr, rf_wdata);
    end
    tick();
    tests++;
    if (rf_wen !== 1'b0) begin
      fails++;
      $display("FAIL dual_empty got %b want 0", rf_wen);
    end
  endtask

  // Four loads and six ALU results streamed together. Count sits at
  // 3 from the third cycle, so the ALU stalls while loads remain.
  task automatic test_backpressure();
    bit          exp_ar[8];
    logic [36:0] exp_log[10];
    int          mi;
    int          ai;
    int          cyc;
    bit          mt;
    bit          at;
    exp_ar = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};
    exp_log = '{
      {5'd16, 32'hC000}, {5'd20, 32'hD000},
      {5'd17, 32'hC001}, {5'd21, 32'hD001},
      {5'd18, 32'hC002}, {5'd19, 32'hC003},
      {5'd22, 32'hD002}, {5'd23, 32'hD003},
      {5'd24, 32'hD004}, {5'd25, 32'hD005}};
    log_q.delete();
    mi = 0;
    ai = 0;
    cyc = 0;
    while ((mi < 4 || ai < 6) && cyc < 20) begin
      mem_valid = (mi < 4);
      mem_addr  = 5'(16 + mi);
      mem_data  = 32'hC000 + 32'(mi);
      alu_valid = (ai < 6);
      alu_addr  = 5'(20 + ai);
      alu_data  = 32'hD000 + 32'(ai);
      #1;
      if (mem_valid) begin
        tests++;
        if (mem_ready !== 1'b1) begin
          fails++;
          $display("FAIL bp_mem_ready cyc %0d got %b want 1",
                   cyc, mem_ready);
        end
      end
      if (cyc < 8) begin
        tests++;
        if (alu_ready !== exp_ar[cyc]) begin
          fails++;
          $display("FAIL bp_alu_ready cyc %0d got %b want %b",
                   cyc, alu_ready, exp_ar[cyc]);
        end
      end
      mt = mem_valid && mem_ready;
      at = alu_valid && alu_ready;
      tick();
      if (mt) mi++;
      if (at) ai++;
      cyc++;
    end
    idle();
    tests++;
    if (cyc != 8) begin
      fails++;
      $display("FAIL bp_cycles got %0d want 8", cyc);
    end
    repeat (5) tick();
    tests++;
    if (log_q.size() != 10) begin
      fails++;
      $display("FAIL bp_commit_count got %0d want 10", log_q.size());
    end
    for (int i = 0; i < 10 && i < log_q.size(); i++) begin
      tests++;
      if (log_q[i] !== exp_log[i]) begin
        fails++;
        $display("FAIL bp_commit %0d got %h want %h",
                 i, log_q[i], exp_log[i]);
      end
    end
  endtask

  task automatic test_bypass();
    mem_valid = 1'b1;
    mem_addr  = 5'd5;
    mem_data  = 32'h11;
    alu_valid = 1'b1;
    alu_addr  = 5'd5;
    alu_data  = 32'h22;
    byp_addr1 = 5'd5;
    byp_addr2 = 5'd0;
    #1;
    tests++;
    if (byp_hit1 !== 1'b0) begin
      fails++;
      $display("FAIL byp_inputs_not_searched got %b want 0", byp_hit1);
    end
    tick();
    idle();
    tests++;
    if ({byp_hit1, byp_data1} !== {1'b1, 32'h22}) begin
      fails++;
      $display("FAIL byp_youngest got %b/%h want 1/22",
               byp_hit1, byp_data1);
    end
    tests++;
    if ({byp_hit2, byp_data2} !== 33'd0) begin
      fails++;
      $display("FAIL byp_r0 got %b/%h want 0/0", byp_hit2, byp_data2);
    end
    byp_addr2 = 5'd9;
    #1;
    tests++;
    if ({byp_hit2, byp_data2} !== 33'd0) begin
      fails++;
      $display("FAIL byp_miss got %b/%h want 0/0", byp_hit2, byp_data2);
    end
    tick();
    tests++;
    if ({byp_hit1, byp_data1} !== {1'b1, 32'h22}) begin
      fails++;
      $display("FAIL byp_head got %b/%h want 1/22",
               byp_hit1, byp_data1);
    end
    tick();
    tests++;
    if ({byp_hit1, byp_data1} !== 33'd0) begin
      fails++;
      $display("FAIL byp_drained got %b/%h want 0/0",
               byp_hit1, byp_data1);
    end
  endtask

  task automatic test_r0_and_reset();
    alu_valid = 1'b1;
    alu_addr  = 5'd0;
    alu_data  = 32'hDEAD;
    #1;
    tests++;
    if (alu_ready !== 1'b1) begin
      fails++;
      $display("FAIL r0_ready got %b want 1", alu_ready);
    end
    tick();
    idle();
    tests++;
    if (rf_wen !== 1'b0) begin
      fails++;
      $display("FAIL r0_dropped got rf_wen %b want 0", rf_wen);
    end
    mem_valid = 1'b1;
    mem_addr  = 5'd1;
    mem_data  = 32'h101;
    alu_valid = 1'b1;
    alu_addr  = 5'd2;
    alu_data  = 32'h202;
    tick();
    alu_valid = 1'b0;
    mem_addr  = 5'd3;
    mem_data  = 32'h303;
    tick();
    idle();
    byp_addr1 = 5'd3;
    #1;
    tests++;
    if ({rf_wen, byp_hit1} !== 2'b11) begin
      fails++;
      $display("FAIL pre_reset got wen/hit %b want 11",
               {rf_wen, byp_hit1});
    end
    reset = 1'b1;
    #1;
    tests++;
    if ({rf_wen, rf_waddr, rf_wdata, byp_hit1} !== 39'd0) begin
      fails++;
      $display("FAIL reset_mid got %b/%0d/%h hit %b want 0/0/0 hit 0",
               rf_wen, rf_waddr, rf_wdata, byp_hit1);
    end
    tick();
    reset = 1'b0;
    log_q.delete();
    repeat (3) tick();
    tests++;
    if (log_q.size() != 0 || rf_wen !== 1'b0) begin
      fails++;
      $display("FAIL post_reset got %0d writes wen %b want 0 writes wen 0",
               log_q.size(), rf_wen);
    end
  endtask

  initial begin
    test_reset();
    test_single_push();
    test_dual_push();
    test_backpressure();
    test_bypass();
    test_r0_and_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
